// File: rtl/pwm_multi_channel_if.sv
// Control/status bundle for the multi-channel PWM block.
// The master side drives the programming and enable signals; the slave
// side (the PWM core) returns the channel outputs and frame status.
interface pwm_multi_channel_if #(
  parameter int CH_COUNT  = 4,
  parameter int CNT_WIDTH = 16
);
  logic                 enable;
  logic [CNT_WIDTH-1:0] period_in;
  logic                 period_we;
  logic [CNT_WIDTH-1:0] duty_in;
  logic [CH_COUNT-1:0]  duty_we;
  logic [CH_COUNT-1:0]  polarity;
  logic [CH_COUNT-1:0]  out;
  logic                 period_start;
  logic                 update_pending;

  modport master (
    output enable, period_in, period_we, duty_in, duty_we, polarity,
    input  out, period_start, update_pending
  );

  modport slave (
    input  enable, period_in, period_we, duty_in, duty_we, polarity,
    output out, period_start, update_pending
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with one shared period counter.
// Period and duty values are written into shadow registers and move into
// the active registers only at a period boundary (or continuously while
// disabled), so a running waveform never sees a partial update. A write
// landing on the wrap cycle bypasses the shadow and takes effect at once.
module pwm_multi_channel #(
  parameter int CH_COUNT       = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int PERIOD_DEFAULT = 50000,
  parameter int DUTY_DEFAULT   = 25000
) (
  input logic                clk,
  input logic                reset,
  pwm_multi_channel_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] PERIOD_INIT = CNT_WIDTH'(PERIOD_DEFAULT);
  localparam logic [CNT_WIDTH-1:0] DUTY_INIT   = CNT_WIDTH'(DUTY_DEFAULT);
  localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [CNT_WIDTH-1:0] period_act_reg, period_sh_reg;
  logic [CNT_WIDTH-1:0] period_eff, period_wr;
  logic [CNT_WIDTH-1:0] duty_act_reg [CH_COUNT];
  logic [CNT_WIDTH-1:0] duty_sh_reg  [CH_COUNT];
  logic [CNT_WIDTH-1:0] duty_wr      [CH_COUNT];
  logic [CH_COUNT-1:0]  out_reg, out_next;
  logic                 period_start_reg, period_start_next;
  logic                 pending_reg, pending_next;
  logic                 wrap, commit;

  // Counter control, commit decision and frame status.
  always_comb begin
    period_eff        = (period_act_reg == '0) ? ONE : period_act_reg;
    wrap              = bus.enable && (cnt_reg == period_eff - ONE);
    commit            = wrap || !bus.enable;
    // A period write in the commit cycle goes straight to the active register.
    period_wr         = bus.period_we ? bus.period_in : period_sh_reg;
    cnt_next          = (!bus.enable || wrap) ? '0 : cnt_reg + ONE;
    period_start_next = bus.enable && (cnt_reg == '0);
    pending_next      = commit ? 1'b0 : (pending_reg | bus.period_we | (|bus.duty_we));
  end

  // Per-channel duty bypass and output compare.
  generate
    for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_ch
      assign duty_wr[gi]  = bus.duty_we[gi] ? bus.duty_in : duty_sh_reg[gi];
      assign out_next[gi] = bus.enable ? ((cnt_reg < duty_act_reg[gi]) ^ bus.polarity[gi])
                                       : bus.polarity[gi];
    end
  endgenerate

  // Counter, period registers, output and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg          <= '0;
      period_act_reg   <= PERIOD_INIT;
      period_sh_reg    <= PERIOD_INIT;
      out_reg          <= '0;
      period_start_reg <= 1'b0;
      pending_reg      <= 1'b0;
    end else begin
      cnt_reg          <= cnt_next;
      out_reg          <= out_next;
      period_start_reg <= period_start_next;
      pending_reg      <= pending_next;
      if (bus.period_we) period_sh_reg <= bus.period_in;
      if (commit)        period_act_reg <= period_wr;
    end
  end

  // Duty shadow and active registers for every channel.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH_COUNT; i++) begin
      if (reset) begin
        duty_sh_reg[i]  <= DUTY_INIT;
        duty_act_reg[i] <= DUTY_INIT;
      end else begin
        if (bus.duty_we[i]) duty_sh_reg[i] <= bus.duty_in;
        if (commit)         duty_act_reg[i] <= duty_wr[i];
      end
    end
  end

  assign bus.out            = out_reg;
  assign bus.period_start   = period_start_reg;
  assign bus.update_pending = pending_reg;

endmodule
